// File: rtl/spi_rx_ip.sv
// SPI receive-only slave (mode 0): synchronizes scl/sda/cs into the clk domain,
// assembles bytes on scl rising edges and hands them to a consumer via valid/rd_ack.
module spi_rx_ip #(
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    input  logic       cs,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    // Handshake: valid is a level that stays high until rd_ack is sampled high;
    // a byte completing in the same cycle as rd_ack keeps valid high.

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic                   scl_prev_q, scl_prev_d;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_q, busy_d;

    logic       sync_scl;
    logic       sync_sda;
    logic       sync_cs;
    logic       scl_rise;
    logic       byte_done;
    logic [7:0] shift_next;

    assign sync_scl = scl_sync_q[SYNC_STAGES-1];
    assign sync_sda = sda_sync_q[SYNC_STAGES-1];
    assign sync_cs  = cs_sync_q[SYNC_STAGES-1];
    assign scl_rise = sync_scl & ~scl_prev_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
        scl_prev_d = sync_scl;
    end

    // The byte as it will look once the bit now being sampled is included.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[6:0], sync_sda};
        end else begin
            shift_next = {sync_sda, shift_q[7:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!sync_cs) begin
                    state_d   = RECV;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            RECV: begin
                // Deselect wins over a coincident scl edge.
                if (sync_cs) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    shift_d     = 8'h00;
                end else if (scl_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    byte_done = (bit_cnt_q == 3'd7);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;

        if (byte_done) begin
            data_out_d = shift_next;
            valid_d    = 1'b1;
            if (valid_q && !rd_ack) begin
                overrun_d = 1'b1;
            end
        end else if (rd_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q  <= '0;
            sda_sync_q  <= '0;
            cs_sync_q   <= '1;
            scl_prev_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            cs_sync_q   <= cs_sync_d;
            scl_prev_q  <= scl_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_rx_ip.sv
// Directed bench for spi_rx_ip: an MSB-first instance and an LSB-first instance
// share clk/reset; expected bytes go through a queue and are checked on delivery.
module tb_spi_rx_ip;

    localparam int SYNC = 2;

    logic             clk;
    logic             reset;
    logic [1:0]       scl;
    logic [1:0]       sda;
    logic [1:0]       cs;
    logic [1:0]       rd_ack;
    logic [1:0][7:0]  data_out;
    logic [1:0]       valid;
    logic [1:0]       overrun;
    logic [1:0]       frame_err;
    logic [1:0]       busy;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;
    int         lat;
    int         fe_cnt;

    spi_rx_ip #(.SYNC_STAGES(SYNC), .MSB_FIRST(1)) u_dut_msb (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl[0]),
        .sda       (sda[0]),
        .cs        (cs[0]),
        .rd_ack    (rd_ack[0]),
        .data_out  (data_out[0]),
        .valid     (valid[0]),
        .overrun   (overrun[0]),
        .frame_err (frame_err[0]),
        .busy      (busy[0])
    );

    spi_rx_ip #(.SYNC_STAGES(SYNC), .MSB_FIRST(0)) u_dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl[1]),
        .sda       (sda[1]),
        .cs        (cs[1]),
        .rd_ack    (rd_ack[1]),
        .data_out  (data_out[1]),
        .valid     (valid[1]),
        .overrun   (overrun[1]),
        .frame_err (frame_err[1]),
        .busy      (busy[1])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic cs_low(input int d);
        @(negedge clk);
        cs[d] = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // Raises cs and counts the cycles frame_err is seen high afterwards.
    task automatic cs_high(input int d, output int pulses);
        pulses = 0;
        @(negedge clk);
        cs[d] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_err[d]) pulses++;
        end
    endtask

    task automatic ack_pulse(input int d);
        @(negedge clk);
        rd_ack[d] = 1'b1;
        @(negedge clk);
        rd_ack[d] = 1'b0;
    endtask

    // Sends nbits of val with a 16-clk scl period. On the last bit it can
    // measure clk edges to valid, or hold rd_ack high on the completing edge.
    task automatic send_bits(input int d, input logic [7:0] val, input int nbits,
                             input bit msb, input bit measure, input bit ack_at_end,
                             output int latency);
        latency = 0;
        if (nbits == 8) exp_q.push_back(val);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sda[d] = msb ? val[7-i] : val[i];
            repeat (8) @(negedge clk);
            scl[d] = 1'b1;
            if (i == nbits - 1 && measure) begin
                while (!valid[d] && latency < 10) begin
                    @(posedge clk);
                    #1;
                    latency++;
                end
            end
            if (i == nbits - 1 && ack_at_end) begin
                repeat (2) @(negedge clk);
                rd_ack[d] = 1'b1;
                @(negedge clk);
                rd_ack[d] = 1'b0;
            end
            repeat (8) @(negedge clk);
            scl[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: the delivered byte must match the oldest expected one.
    task automatic expect_byte(input int d, input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, valid[d]}, 32'd1);
            check({tag, "_data"}, {24'd0, data_out[d]}, {24'd0, exp});
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check({tag, "_data"}, {24'd0, data_out[d]}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid[d]}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun[d]}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err[d]}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy[d]}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        scl      = 2'b00;
        sda      = 2'b00;
        cs       = 2'b11;
        rd_ack   = 2'b00;
        repeat (4) @(negedge clk);
        check_all_zero(0, "reset_msb");
        check_all_zero(1, "reset_lsb");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte with latency measurement
        cs_low(0);
        check("s1_busy_after_cs", {31'd0, busy[0]}, 32'd1);
        send_bits(0, 8'hA5, 8, 1'b1, 1'b1, 1'b0, lat);
        check("s1_latency", lat, SYNC + 1);
        expect_byte(0, "s1");
        check("s1_busy_in_frame", {31'd0, busy[0]}, 32'd1);
        cs_high(0, fe_cnt);
        check("s1_no_frame_err", fe_cnt, 0);
        check("s1_busy_after_cs_high", {31'd0, busy[0]}, 32'd0);
        check("s1_valid_held", {31'd0, valid[0]}, 32'd1);
        ack_pulse(0);
        check("s1_ack_clears", {31'd0, valid[0]}, 32'd0);

        // Acknowledge
        cs_low(0);
        send_bits(0, 8'h3C, 8, 1'b1, 1'b0, 1'b0, lat);
        expect_byte(0, "s2");
        cs_high(0, fe_cnt);
        ack_pulse(0);
        check("s2_valid_after_ack", {31'd0, valid[0]}, 32'd0);
        check("s2_data_kept", {24'd0, data_out[0]}, 32'h3C);

        // Overrun in a continuous two-byte frame
        cs_low(0);
        send_bits(0, 8'h11, 8, 1'b1, 1'b0, 1'b0, lat);
        expect_byte(0, "s3_first");
        check("s3_no_overrun_yet", {31'd0, overrun[0]}, 32'd0);
        send_bits(0, 8'h22, 8, 1'b1, 1'b0, 1'b0, lat);
        expect_byte(0, "s3_second");
        check("s3_overrun_set", {31'd0, overrun[0]}, 32'd1);
        cs_high(0, fe_cnt);
        check("s3_overrun_sticky", {31'd0, overrun[0]}, 32'd1);
        ack_pulse(0);
        check("s3_valid_cleared", {31'd0, valid[0]}, 32'd0);
        check("s3_overrun_cleared", {31'd0, overrun[0]}, 32'd0);

        // Abort after 5 bits, then a clean frame
        cs_low(0);
        send_bits(0, 8'hF0, 5, 1'b1, 1'b0, 1'b0, lat);
        cs_high(0, fe_cnt);
        check("s4_frame_err_one_cycle", fe_cnt, 1);
        check("s4_valid_unchanged", {31'd0, valid[0]}, 32'd0);
        check("s4_data_unchanged", {24'd0, data_out[0]}, 32'h22);
        cs_low(0);
        send_bits(0, 8'hC3, 8, 1'b1, 1'b0, 1'b0, lat);
        expect_byte(0, "s4_next");
        cs_high(0, fe_cnt);
        check("s4_clean_end", fe_cnt, 0);

        // rd_ack on the completing edge, with C3 still unacknowledged
        cs_low(0);
        send_bits(0, 8'h7E, 8, 1'b1, 1'b0, 1'b1, lat);
        expect_byte(0, "s5");
        check("s5_no_overrun", {31'd0, overrun[0]}, 32'd0);
        cs_high(0, fe_cnt);

        // Reset mid-byte on the LSB-first instance, then an LSB-first byte
        cs_low(1);
        send_bits(1, 8'hFF, 3, 1'b0, 1'b0, 1'b0, lat);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero(1, "s6_reset_lsb");
        check_all_zero(0, "s6_reset_msb");
        reset = 1'b0;
        fe_cnt = 0;
        repeat (SYNC + 3) begin
            @(negedge clk);
            if (frame_err[1]) fe_cnt++;
        end
        check("s6_no_frame_err", fe_cnt, 0);
        send_bits(1, 8'h01, 8, 1'b0, 1'b0, 1'b0, lat);
        expect_byte(1, "s6_lsb");
        cs_high(1, fe_cnt);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rx_ip.md
SPI_RX_IP -- requirements
Module: spi_rx_ip

Interface
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, the number of synchronizer flops on each of scl, sda and cs (legal 2..4).
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1; 1 means the first received bit is data_out[7], and 0 means the first received bit is data_out[0].
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 scl  input  1  SPI clock pin from the master, asynchronous to clk; idle low.
REQ-006 sda  input  1  SPI data pin from the master (master to slave), asynchronous to clk.
REQ-007 cs  input  1  chip select, active-low, asynchronous to clk.
REQ-008 rd_ack  input  1  consumer acknowledge; a one-cycle high pulse clears valid.
REQ-009 data_out  output  8  last completely received byte.
REQ-010 valid  output  1  level signal: data_out holds an unacknowledged byte.
REQ-011 overrun  output  1  sticky flag: a byte was overwritten before it was acknowledged.
REQ-012 frame_err  output  1  one-cycle pulse: cs was deasserted in the middle of a byte.
REQ-013 busy  output  1  high while the FSM is in RECV.

Function
REQ-014 scl, sda and cs SHALL each pass through a chain of SYNC_STAGES flops; the internal logic uses only the synchronized copies.
REQ-015 Rising-edge detection SHALL compare synchronized scl against a registered copy of itself; scl_rise = sync_scl & ~scl_d.
REQ-016 The FSM SHALL have two states, IDLE and RECV.
REQ-017 IDLE -> RECV SHALL occur when sync_cs is low; on entry, bit_cnt = 0 and the shift register is cleared.
REQ-018 RECV -> IDLE SHALL occur when sync_cs is high.
REQ-019 In RECV, on each scl_rise, the block SHALL shift in sync_sda, ordered per MSB_FIRST, and increment the 3-bit bit_cnt.
REQ-020 Any scl_rise seen while in IDLE SHALL be ignored.
REQ-021 On the scl_rise that carries the 8th bit (bit_cnt == 7), in the same clk edge the block SHALL:
  - load data_out with the full byte, including the bit being sampled;
  - set valid = 1;
  - wrap bit_cnt to 0 while remaining in RECV, so multi-byte frames are continuous.
REQ-022 Latency SHALL be exactly SYNC_STAGES+1 clk edges from the first clk edge that samples scl high (for the 8th bit) to valid = 1.
REQ-023 valid SHALL remain high until rd_ack is sampled high; it then goes low on the next clk edge.
REQ-024 If a byte completes while valid = 1 and rd_ack = 0:
  - data_out is overwritten;
  - valid stays 1;
  - overrun is set to 1.
REQ-025 If a byte completes in the same cycle as rd_ack = 1:
  - data_out takes the new byte;
  - valid stays 1;
  - overrun is unchanged.
REQ-026 overrun SHALL clear on an rd_ack cycle in which no byte completes; otherwise it holds.
REQ-027 If sync_cs goes high in RECV with bit_cnt != 0:
  - frame_err pulses high for exactly one cycle;
  - the partial byte is discarded;
  - data_out and valid are unaffected.
REQ-028 If sync_cs goes high in RECV with bit_cnt == 0, the block SHALL NOT raise frame_err.
REQ-029 If sync_cs high and scl_rise occur in the same cycle, cs SHALL take priority: the edge is not shifted in and REQ-027/REQ-028 apply.
REQ-030 busy SHALL equal (state == RECV), registered.

Reset
REQ-031 While reset is high, the block SHALL set:
  - state to IDLE;
  - bit_cnt and the shift register to 0;
  - data_out to 8'h00;
  - valid, overrun, frame_err and busy to 0;
  - all synchronizer flops to scl = 0, sda = 0, cs = 1.
REQ-032 Reset asserted mid-byte SHALL discard the partial byte without a frame_err pulse.
REQ-033 After reset deasserts, the first byte SHALL be received correctly once cs has been seen low for SYNC_STAGES cycles before the first scl rise.

Verification
REQ-034 The bench SHALL cover the following scenarios:
  - Single byte: cs low, 8'hA5 MSB-first with scl period 16 clk -> valid rises SYNC_STAGES+1 edges after the 8th scl high sample, data_out = 8'hA5, busy = 1 until cs high.
  - Acknowledge: byte 8'h3C, pulse rd_ack -> valid = 0 the next cycle, data_out stays 8'h3C.
  - Overrun: bytes 8'h11 then 8'h22 with no rd_ack -> data_out = 8'h22, valid = 1, overrun = 1; a later rd_ack clears both valid and overrun.
  - Abort: cs high after 5 bits -> one-cycle frame_err, valid unchanged; the next full frame 8'hC3 is received correctly.
  - Simultaneous: rd_ack coincides with completion of 8'h7E -> valid = 1, data_out = 8'h7E, overrun = 0.
  - Reset mid-byte plus MSB_FIRST = 0: reset after 3 bits -> all outputs 0; then 8'h01 sent LSB-first -> data_out = 8'h01.
